// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer onto a single-port synchronous SRAM, with byte/half read-modify-write.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RMW_RD, RMW_WR, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [ADDR_W-1:0] addr_last_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q, wdata_last_q, rdata_q;
  logic              err_q;
  logic              accept, err, acc_st;
  logic [31:0]       sh_rd, fmt, mask, merged;
  logic [15:0]       half_v;
  logic [4:0]        lane_sh;
  logic              unused_addr;
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign req_ready = (state_q == IDLE) & ~rst;
  assign accept = req_valid & req_ready;
  assign err = (memwrite | memread) &
               ((memwrite ? (funct3 > 3'b010) : (funct3 == 3'b011 || funct3[2:1] == 2'b11)) |
                (funct3[1:0] == 2'b01 & addr[0]) | (funct3[1:0] == 2'b10 & |addr[1:0]));
  assign lane_sh = {addr_q[1:0], 3'b000};
  assign sh_rd = sram_rdata >> lane_sh;
  assign half_v = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
  assign fmt = f3_q == 3'b000 ? {{24{sh_rd[7]}}, sh_rd[7:0]} :
               f3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
               f3_q == 3'b100 ? {24'b0, sh_rd[7:0]} :
               f3_q == 3'b101 ? {16'b0, half_v} : sram_rdata;
  // Halfword stores are aligned by this point, so the byte-lane shift also places the half lane.
  assign mask = f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  assign merged = (sram_rdata & ~(mask << lane_sh)) | ((wdata_q & mask) << lane_sh);
  assign acc_st = state_q inside {RD, WR, RMW_RD, RMW_WR};
  assign sram_en = acc_st & ~rst;
  assign sram_we = (state_q == WR || state_q == RMW_WR) & ~rst;
  assign sram_addr = acc_st ? addr_q[ADDR_W+1:2] : addr_last_q;
  assign sram_wdata = state_q == WR ? wdata_q : state_q == RMW_WR ? merged : wdata_last_q;
  assign resp_valid = state_q == RESP;
  assign misaligned = (state_q == RESP) & err_q;
  assign rdata = rdata_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !accept ? IDLE :
                         (err || !(memwrite || memread)) ? RESP :
                         !memwrite ? RD : funct3 == 3'b010 ? WR : RMW_RD;
      RD:      state_d = CAP;
      CAP:     state_d = RESP;
      WR:      state_d = RESP;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      addr_last_q  <= '0;
      wdata_last_q <= '0;
      addr_q       <= '0;
      f3_q         <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_last_q  <= sram_addr;
      wdata_last_q <= sram_wdata;
      if (accept) begin
        addr_q  <= addr[ADDR_W+1:0];
        f3_q    <= funct3;
        wdata_q <= wdata;
        err_q   <= err;
      end
      if (accept && err) rdata_q <= '0;
      else if (state_q == CAP) rdata_q <= fmt;
    end
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 10, SRAM word-address width (SRAM depth 2^ADDR_W 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 memread  input  1  load request qualifier.
REQ-007 memwrite  input  1  store request qualifier; overrides memread.
REQ-008 funct3  input  3  RV32I access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  formatted load result, registered.
REQ-013 misaligned  output  1  error flag, valid with resp_valid.
REQ-014 sram_en  output  1  SRAM access strobe.
REQ-015 sram_we  output  1  SRAM write enable, qualified by sram_en.
REQ-016 sram_addr  output  ADDR_W  word address = addr[ADDR_W+1:2].
REQ-017 sram_wdata  output  32  SRAM write word.
REQ-018 sram_rdata  input  32  SRAM read word, valid the cycle after a read strobe.

Function
REQ-019 FSM states: IDLE, RD, CAP, WR, RMW_RD, RMW_WR, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE with rst low; accept = req_valid & req_ready; addr, funct3, wdata and type are captured on accept.
REQ-021 Accept with memwrite=0 and memread=0 SHALL go to RESP with misaligned=0, no SRAM access.
REQ-022 Error: halfword with addr[0]=1, word with addr[1:0]!=00, load funct3 in {011,110,111}, or store funct3 above 010; the FSM SHALL go IDLE->RESP with misaligned=1, rdata=0, and no SRAM access.
REQ-023 Load path IDLE->RD->CAP->RESP; RD drives sram_en=1, sram_we=0; CAP registers the formatted rdata; resp_valid is high at accept+3.
REQ-024 Load format little-endian: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
REQ-025 SW path IDLE->WR->RESP; WR drives sram_en=1, sram_we=1, sram_wdata=wdata; resp_valid is high at accept+2.
REQ-026 SB/SH path IDLE->RMW_RD->RMW_WR->RESP; RMW_RD reads the word; RMW_WR writes sram_rdata with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]; resp_valid is high at accept+3.
REQ-027 RESP lasts exactly one cycle, then IDLE; no response backpressure.
REQ-028 rdata SHALL hold its value until the next load or error response; store responses leave rdata unchanged.
REQ-029 misaligned SHALL be 0 except in an error RESP cycle.
REQ-030 addr bits above ADDR_W+1 are ignored; the word address wraps modulo 2^ADDR_W.
REQ-031 sram_en/sram_we SHALL be 0 in IDLE, CAP and RESP; sram_addr and sram_wdata hold their last value when unstrobed.

Reset
REQ-032 rst SHALL force IDLE on the next edge; rdata=0, misaligned=0, resp_valid=0.
REQ-033 sram_en and sram_we SHALL be gated combinationally by ~rst, so no write occurs in a cycle with rst high.
REQ-034 Reset mid-transaction SHALL abort it with no resp_valid; req_ready=1 in the first cycle after rst deasserts.

Verification
REQ-035 Mem word 0x4 = 0x80FF_1234; LB addr 0x5 -> rdata 0x0000_0012 at accept+3; LBU addr 0x7 -> 0x0000_0080; LB addr 0x7 -> 0xFFFF_FF80.
REQ-036 LH addr 0x6 on the same word -> rdata 0xFFFF_80FF; LHU -> 0x0000_80FF; LW addr 0x4 -> 0x80FF_1234.
REQ-037 SH addr 0x6 with wdata 0xAAAA_BEEF on word 0x80FF_1234 -> SRAM write 0xBEEF_1234 in RMW_WR; resp_valid at accept+3.
REQ-038 LW addr 0x2 and SH addr 0x3 -> resp_valid at accept+1, misaligned=1, rdata=0, sram_en never asserted.
REQ-039 rst asserted during RMW_WR -> no SRAM write, no resp_valid, FSM in IDLE, req_ready=1 on the first cycle after rst deasserts.
REQ-040 Back-to-back requests with req_valid held high -> the second request is accepted the cycle after RESP; ADDR_W=10 with addr 0x1004 maps to sram_addr 1.
